// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// All patterns here are active-high; output polarity is applied at the output registers.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0]            SEG_OFF = 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = '0;

  // gfedcba codes, element n is the glyph for hex digit n
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    lz;
  } disp_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Upstream load port and display pins of the scan driver.
// master = upstream mode/counter logic, slave = the scan driver itself.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic                    load;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   led_sel;
  logic [7:0]              led;

  modport master (
    output data_in, dp_in, blank_lz, load,
    input  frame_done, led_sel, led
  );

  modport slave (
    input  data_in, dp_in, blank_lz, load,
    output frame_done, led_sel, led
  );

endinterface

// File: rtl/seg7_decoder.sv
// Nibble + dp to active-high {dp,g..a}; purely combinational, no backpressure.
// A blanked digit drops its glyph but keeps the decimal point.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = {dp, blank ? 7'h00 : SEG_TABLE[nibble]};
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 4-digit multiplexed display driver; outputs 1 cycle behind the scan counters.
// load is always accepted (no backpressure); new values take effect only at a frame boundary.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] SEL_POL = ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]            SEG_POL = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [1:0]            LAST_DIG = 2'(NUM_DIGITS - 1);

  logic [SW-1:0]         slot_cnt;
  logic [1:0]            dig_idx;
  disp_t                 pend_q;
  disp_t                 act_q;
  logic                  pend_valid;
  logic                  frame_done_q;
  logic [NUM_DIGITS-1:0] led_sel_q;
  logic [7:0]            led_q;

  logic                  slot_end;
  logic                  frame_end;
  logic                  frame_pre_end;
  logic                  in_blank;
  disp_t                 load_val;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [3:0]            cur_nib;
  logic [7:0]            dec_seg;
  logic [NUM_DIGITS-1:0] sel_hi;
  logic [7:0]            seg_hi;

  always_comb begin
    slot_end      = (slot_cnt == SW'(REFRESH_DIV - 1));
    frame_end     = slot_end && (dig_idx == LAST_DIG);
    // frame_done is registered, so arm it one cycle early to land on the wrap cycle
    frame_pre_end = (slot_cnt == SW'(REFRESH_DIV - 2)) && (dig_idx == LAST_DIG);
    in_blank      = (slot_cnt < SW'(BLANK_CYCLES));
    load_val      = '{data: bus.data_in, dp: bus.dp_in, lz: bus.blank_lz};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt     <= '0;
      dig_idx      <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_cnt     <= slot_end ? '0 : slot_cnt + SW'(1);
      frame_done_q <= frame_pre_end;
      if (slot_end) begin
        dig_idx <= dig_idx + 2'd1;
      end
      // a load coinciding with the wrap bypasses pending so it is not lost for a frame
      if (frame_end) begin
        if (bus.load) begin
          act_q <= load_val;
        end else if (pend_valid) begin
          act_q <= pend_q;
        end
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_q     <= load_val;
        pend_valid <= 1'b1;
      end
    end
  end

  // digit i blanks only when it and every more-significant nibble are zero
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = act_q.lz && (act_q.data[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (act_q.data[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (act_q.data[7:4] == 4'h0);
    cur_nib     = act_q.data[{dig_idx, 2'b00} +: 4];
  end

  seg7_decoder u_decoder (
    .nibble (cur_nib),
    .dp     (act_q.dp[dig_idx]),
    .blank  (lz_blank[dig_idx]),
    .seg    (dec_seg)
  );

  always_comb begin
    sel_hi = SEL_OFF;
    seg_hi = SEG_OFF;
    if (!in_blank) begin
      sel_hi          = SEL_OFF;
      sel_hi[dig_idx] = 1'b1;
      seg_hi          = dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_sel_q <= SEL_OFF ^ SEL_POL;
      led_q     <= SEG_OFF ^ SEG_POL;
    end else begin
      led_sel_q <= sel_hi ^ SEL_POL;
      led_q     <= seg_hi ^ SEG_POL;
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.led_sel    = led_sel_q;
  assign bus.led        = led_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with an 8-cycle slot, 2 blank cycles, active-low outputs.
module tb_seg7_scan_driver;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame of outputs, index p = slot position 0..31 counted from digit 0 slot 0
  logic [3:0] cap_sel [32];
  logic [7:0] cap_led [32];
  logic       cap_fd  [32];
  bit         cap_ok;

  // Expected pins for frame position p with active-low per-digit led codes
  function automatic logic [3:0] exp_sel(input int p);
    logic [3:0] one;
    one = 4'b0001;
    if ((p % 8) < 2) return 4'hF;
    return ~(one << (p / 8));
  endfunction

  function automatic logic [7:0] exp_led(input int p, input logic [3:0][7:0] codes);
    if ((p % 8) < 2) return 8'hFF;
    return codes[p / 8];
  endfunction

  // Sync to the next frame_done and record the frame that follows it; optionally
  // pulse load at offset load_k cycles after the frame_done cycle (0 = on it).
  task automatic capture_frame(input int load_k, input logic [15:0] d,
                               input logic [3:0] dp, input logic lz);
    int n;
    n      = 0;
    cap_ok = 1'b0;
    while (bus.frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.frame_done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL frame_sync: frame_done=%b after %0d cycles, required 1", bus.frame_done, n);
      return;
    end
    cap_ok = 1'b1;
    if (load_k == 0) begin
      bus.data_in = d; bus.dp_in = dp; bus.blank_lz = lz; bus.load = 1'b1;
    end
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (k >= 2) begin
        cap_sel[k-2] = bus.led_sel;
        cap_led[k-2] = bus.led;
        cap_fd[k-2]  = bus.frame_done;
      end
      if (k == load_k) begin
        bus.data_in = d; bus.dp_in = dp; bus.blank_lz = lz; bus.load = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.led_sel !== 4'hF || bus.led !== 8'hFF || bus.frame_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold c=%0d: sel=%b led=%h fd=%b, required 1111/ff/0",
                 c, bus.led_sel, bus.led, bus.frame_done);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (c < 3 && (bus.led_sel !== 4'hF || bus.led !== 8'hFF)) begin
        miscompares++;
        $display("FAIL reset_release c=%0d: sel=%b led=%h, required 1111/ff", c, bus.led_sel, bus.led);
      end else if (c == 3 && (bus.led_sel !== 4'b1110 || bus.led !== 8'hC0)) begin
        miscompares++;
        $display("FAIL reset_first_lit: sel=%b led=%h, required 1110/c0", bus.led_sel, bus.led);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0][7:0] codes;
    codes = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    bus.data_in = 16'h1234; bus.dp_in = 4'h0; bus.blank_lz = 1'b0; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    capture_frame(-1, 16'h0, 4'h0, 1'b0);
    for (int p = 0; p < 32 && cap_ok; p++) begin
      vectors++;
      if (cap_sel[p] !== exp_sel(p) || cap_led[p] !== exp_led(p, codes) || cap_fd[p] !== (p == 30)) begin
        miscompares++;
        $display("FAIL basic_scan p=%0d: sel=%b led=%h fd=%b, required %b/%h/%b",
                 p, cap_sel[p], cap_led[p], cap_fd[p], exp_sel(p), exp_led(p, codes), (p == 30));
      end
    end
  endtask

  task automatic test_tear_free();
    logic [3:0][7:0] old_codes;
    logic [3:0][7:0] new_codes;
    old_codes = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    new_codes = {8'h88, 8'h83, 8'hC6, 8'hA1};
    capture_frame(12, 16'hABCD, 4'h0, 1'b0);
    for (int p = 0; p < 32 && cap_ok; p++) begin
      vectors++;
      if (cap_sel[p] !== exp_sel(p) || cap_led[p] !== exp_led(p, old_codes)) begin
        miscompares++;
        $display("FAIL tear_hold p=%0d: sel=%b led=%h, required %b/%h",
                 p, cap_sel[p], cap_led[p], exp_sel(p), exp_led(p, old_codes));
      end
    end
    capture_frame(-1, 16'h0, 4'h0, 1'b0);
    for (int p = 0; p < 32 && cap_ok; p++) begin
      vectors++;
      if (cap_sel[p] !== exp_sel(p) || cap_led[p] !== exp_led(p, new_codes)) begin
        miscompares++;
        $display("FAIL tear_update p=%0d: sel=%b led=%h, required %b/%h",
                 p, cap_sel[p], cap_led[p], exp_sel(p), exp_led(p, new_codes));
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [3:0][7:0] codes;
    codes = {8'hFF, 8'h7F, 8'hFF, 8'hF8};
    bus.data_in = 16'h0007; bus.dp_in = 4'b0100; bus.blank_lz = 1'b1; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_in = 4'h0;
    capture_frame(-1, 16'h0, 4'h0, 1'b0);
    for (int p = 0; p < 32 && cap_ok; p++) begin
      vectors++;
      if (cap_sel[p] !== exp_sel(p) || cap_led[p] !== exp_led(p, codes)) begin
        miscompares++;
        $display("FAIL leading_zeros p=%0d: sel=%b led=%h, required %b/%h",
                 p, cap_sel[p], cap_led[p], exp_sel(p), exp_led(p, codes));
      end
    end
  endtask

  task automatic test_load_on_boundary();
    logic [3:0][7:0] codes;
    codes = {8'h80, 8'h80, 8'h80, 8'h80};
    capture_frame(0, 16'h8888, 4'h0, 1'b0);
    for (int p = 0; p < 32 && cap_ok; p++) begin
      vectors++;
      if (cap_sel[p] !== exp_sel(p) || cap_led[p] !== exp_led(p, codes)) begin
        miscompares++;
        $display("FAIL boundary_load p=%0d: sel=%b led=%h, required %b/%h",
                 p, cap_sel[p], cap_led[p], exp_sel(p), exp_led(p, codes));
      end
    end
    vectors++;
    if (dut.pend_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_pend_valid: pend_valid=%b, required 0", dut.pend_valid);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_sync: frame_done=%b, required 1", bus.frame_done);
    end
    // 22 cycles past frame_done lands inside the digit-2 lit window
    repeat (22) @(negedge clk);
    vectors++;
    if (bus.led_sel !== 4'b1011 || bus.led !== 8'h80) begin
      miscompares++;
      $display("FAIL mid_reset_pre: sel=%b led=%h, required 1011/80", bus.led_sel, bus.led);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.led_sel !== 4'hF || bus.led !== 8'hFF || bus.frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async: sel=%b led=%h fd=%b, required 1111/ff/0",
               bus.led_sel, bus.led, bus.frame_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      vectors++;
      if (c < 3 && (bus.led_sel !== 4'hF || bus.led !== 8'hFF)) begin
        miscompares++;
        $display("FAIL mid_reset_release c=%0d: sel=%b led=%h, required 1111/ff", c, bus.led_sel, bus.led);
      end else if (c == 3 && (bus.led_sel !== 4'b1110 || bus.led !== 8'hC0)) begin
        miscompares++;
        $display("FAIL mid_reset_restart: sel=%b led=%h, required 1110/c0", bus.led_sel, bus.led);
      end
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    bus.data_in  = 16'h0;
    bus.dp_in    = 4'h0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;
    test_reset();
    test_basic_scan();
    test_tear_free();
    test_leading_zeros();
    test_load_on_boundary();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
